// File: rtl/ct_ebiu_cawt_pkg.sv
// Shared definitions for the EBIU non-cacheable write table (CAWT).
// Default table geometry, controller FSM encoding and line-index slice bounds.
package ct_ebiu_cawt_pkg;

  localparam int CAWT_ENTRY_DEF = 8;
  localparam int CAWT_IDW_DEF   = 3;
  localparam int CNTW_DEF       = CAWT_IDW_DEF + 1;

  // Entries track a line index taken from address bits [13:6].
  localparam int ADDR_IDX_HI = 13;
  localparam int ADDR_IDX_LO = 6;
  localparam int ADDR_IDX_W  = ADDR_IDX_HI - ADDR_IDX_LO + 1;

  typedef enum logic [1:0] {
    CAWT_IDLE  = 2'b00,
    CAWT_DRAIN = 2'b01,
    CAWT_ACK   = 2'b10
  } cawt_state_e;

endpackage

// File: rtl/ct_ebiu_cawt_alloc.sv
// Fixed-priority free-slot picker: lowest set bit of the free vector wins.
// Purely combinational so any EBIU tracking table can grant in the request cycle.
module ct_ebiu_cawt_alloc #(
  parameter int N   = 8,
  parameter int IDW = 3
) (
  input  logic [N-1:0]   free,
  output logic [N-1:0]   onehot,
  output logic [IDW-1:0] idx,
  output logic           any_free
);

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    onehot = '0;
    idx    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (free[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IDW'(i);
      end
    end
    any_free = |free;
  end

endmodule

// File: rtl/ct_ebiu_cawt_ctrl.sv
// CAWT controller: allocates table entries to VB non-cacheable writes, pops them
// on AXI B responses, blocks/stalls same-line traffic and runs the CIU drain/sync
// handshake. Optional macro CAWT_PERF_CNT_EN adds a saturating 16-bit counter of
// cycles in which a create request was refused.
module ct_ebiu_cawt_ctrl
  import ct_ebiu_cawt_pkg::*;
#(
  parameter int CAWT_ENTRY = CAWT_ENTRY_DEF,
  parameter int CAWT_IDW   = CAWT_IDW_DEF,
  parameter int CNTW       = CNTW_DEF
) (
  input  logic                  cawt_ctrl_clk,
  input  logic                  cpurst_b,
  input  logic                  vb_cawt_create_req,
  output logic                  cawt_vb_create_gnt,
  output logic [CAWT_IDW-1:0]   cawt_create_id,
  output logic [CAWT_ENTRY-1:0] cawt_create_en,
  output logic [CAWT_ENTRY-1:0] cawt_create_dp_en,
  input  logic [CAWT_ENTRY-1:0] cawt_entry_vld,
  input  logic [CAWT_ENTRY-1:0] ca_wr_addr_hit_cawt,
  input  logic [CAWT_ENTRY-1:0] ca_rd_addr_hit_cawt,
  input  logic                  ebiu_cawt_rd_req,
  output logic                  cawt_ebiu_rd_stall,
  input  logic                  cawt_bresp_vld,
  input  logic [CAWT_IDW-1:0]   cawt_bresp_id,
  output logic [CAWT_ENTRY-1:0] cawt_pop_en,
  input  logic                  ciu_cawt_sync_req,
  output logic                  cawt_ciu_sync_ack,
  output logic                  cawt_full,
  output logic                  cawt_empty,
  output logic [CNTW-1:0]       cawt_cnt
`ifdef CAWT_PERF_CNT_EN
  ,
  output logic [15:0]           cawt_perf_full_stall
`endif
);

  cawt_state_e           state_q, state_nxt;
  logic [CAWT_ENTRY-1:0] alloc_oh;
  logic [CAWT_IDW-1:0]   alloc_id;
  logic                  any_free;
  logic                  wr_blk;
  logic                  pop_any;
  logic [CNTW-1:0]       cnt_nxt;

  ct_ebiu_cawt_alloc #(.N(CAWT_ENTRY), .IDW(CAWT_IDW)) u_alloc (
    .free     (~cawt_entry_vld),
    .onehot   (alloc_oh),
    .idx      (alloc_id),
    .any_free (any_free)
  );

  assign cawt_create_id = alloc_id;

  // A write to a line that is still outstanding must wait for its predecessor.
  assign wr_blk = |(ca_wr_addr_hit_cawt & cawt_entry_vld);

  // Reads only need to wait behind a live same-line write; independent of drain.
  assign cawt_ebiu_rd_stall = ebiu_cawt_rd_req & (|(ca_rd_addr_hit_cawt & cawt_entry_vld));

  // Per-entry pop decode; a response naming an idle entry is dropped.
  genvar gi;
  generate
    for (gi = 0; gi < CAWT_ENTRY; gi++) begin : g_pop
      assign cawt_pop_en[gi] = cawt_bresp_vld & (cawt_bresp_id == CAWT_IDW'(gi)) & cawt_entry_vld[gi];
    end
  endgenerate

  assign pop_any = |cawt_pop_en;

  // Create/pop steer to distinct entries, so simultaneous ones cancel out.
  always_comb begin
    cnt_nxt = cawt_cnt;
    case ({cawt_vb_create_gnt, pop_any})
      2'b10:   cnt_nxt = cawt_cnt + CNTW'(1);
      2'b01:   cnt_nxt = cawt_cnt - CNTW'(1);
      default: cnt_nxt = cawt_cnt;
    endcase
  end

  // Occupancy and its registered full/empty flags.
  always_ff @(posedge cawt_ctrl_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      cawt_cnt   <= '0;
      cawt_full  <= 1'b0;
      cawt_empty <= 1'b1;
    end else begin
      cawt_cnt   <= cnt_nxt;
      cawt_full  <= (cnt_nxt == CNTW'(CAWT_ENTRY));
      cawt_empty <= (cnt_nxt == '0);
    end
  end

  // Sync FSM state register.
  always_ff @(posedge cawt_ctrl_clk or negedge cpurst_b) begin
    if (!cpurst_b) state_q <= CAWT_IDLE;
    else           state_q <= state_nxt;
  end

  // Sync FSM next state: an already-empty table acks straight away, else drain first.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      CAWT_IDLE: begin
        if (ciu_cawt_sync_req) begin
          if ((cawt_cnt == '0) && !cawt_vb_create_gnt) state_nxt = CAWT_ACK;
          else                                         state_nxt = CAWT_DRAIN;
        end
      end
      CAWT_DRAIN: if (cnt_nxt == '0) state_nxt = CAWT_ACK;
      CAWT_ACK:   state_nxt = CAWT_IDLE;
      default:    state_nxt = CAWT_IDLE;
    endcase
  end

  // Sync FSM outputs: creates only while idle, ack for the single ACK cycle.
  always_comb begin
    cawt_vb_create_gnt = vb_cawt_create_req & any_free & ~wr_blk & (state_q == CAWT_IDLE);
    cawt_ciu_sync_ack  = (state_q == CAWT_ACK);
    cawt_create_en     = cawt_vb_create_gnt ? alloc_oh : '0;
    cawt_create_dp_en  = cawt_vb_create_gnt ? alloc_oh : '0;
  end

`ifdef CAWT_PERF_CNT_EN
  // Count refused create cycles, sticking at the top value.
  always_ff @(posedge cawt_ctrl_clk or negedge cpurst_b) begin
    if (!cpurst_b)
      cawt_perf_full_stall <= '0;
    else if (vb_cawt_create_req && !cawt_vb_create_gnt && (cawt_perf_full_stall != 16'hFFFF))
      cawt_perf_full_stall <= cawt_perf_full_stall + 16'd1;
  end
`endif

endmodule

// File: tb/tb_ct_ebiu_cawt_ctrl.sv
// Randomized bench for ct_ebiu_cawt_ctrl. The bench owns the entry array (valid
// bits and line tags) and predicts every output from the table rules directly.
module tb_ct_ebiu_cawt_ctrl;

  localparam int N   = 8;
  localparam int IDW = 3;
  localparam int CW  = 4;

  logic           cawt_ctrl_clk = 1'b0;
  logic           cpurst_b;
  logic           vb_cawt_create_req;
  logic           cawt_vb_create_gnt;
  logic [IDW-1:0] cawt_create_id;
  logic [N-1:0]   cawt_create_en, cawt_create_dp_en;
  logic [N-1:0]   cawt_entry_vld, ca_wr_addr_hit_cawt, ca_rd_addr_hit_cawt;
  logic           ebiu_cawt_rd_req, cawt_ebiu_rd_stall;
  logic           cawt_bresp_vld;
  logic [IDW-1:0] cawt_bresp_id;
  logic [N-1:0]   cawt_pop_en;
  logic           ciu_cawt_sync_req, cawt_ciu_sync_ack;
  logic           cawt_full, cawt_empty;
  logic [CW-1:0]  cawt_cnt;
`ifdef CAWT_PERF_CNT_EN
  logic [15:0]    cawt_perf_full_stall;
`endif

  always #5 cawt_ctrl_clk = ~cawt_ctrl_clk;

  ct_ebiu_cawt_ctrl dut (
    .cawt_ctrl_clk       (cawt_ctrl_clk),
    .cpurst_b            (cpurst_b),
    .vb_cawt_create_req  (vb_cawt_create_req),
    .cawt_vb_create_gnt  (cawt_vb_create_gnt),
    .cawt_create_id      (cawt_create_id),
    .cawt_create_en      (cawt_create_en),
    .cawt_create_dp_en   (cawt_create_dp_en),
    .cawt_entry_vld      (cawt_entry_vld),
    .ca_wr_addr_hit_cawt (ca_wr_addr_hit_cawt),
    .ca_rd_addr_hit_cawt (ca_rd_addr_hit_cawt),
    .ebiu_cawt_rd_req    (ebiu_cawt_rd_req),
    .cawt_ebiu_rd_stall  (cawt_ebiu_rd_stall),
    .cawt_bresp_vld      (cawt_bresp_vld),
    .cawt_bresp_id       (cawt_bresp_id),
    .cawt_pop_en         (cawt_pop_en),
    .ciu_cawt_sync_req   (ciu_cawt_sync_req),
    .cawt_ciu_sync_ack   (cawt_ciu_sync_ack),
    .cawt_full           (cawt_full),
    .cawt_empty          (cawt_empty),
    .cawt_cnt            (cawt_cnt)
`ifdef CAWT_PERF_CNT_EN
    ,
    .cawt_perf_full_stall(cawt_perf_full_stall)
`endif
  );

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference state: which entries hold an outstanding write and its line,
  // whether a drain is waiting and whether the ack is due this cycle.
  bit       m_vld [N];
  bit [7:0] m_tag [N];
  bit       m_drain, m_ack;
  int       m_perf;
  bit [7:0] wr_line, rd_line;

  function automatic int occupancy();
    int c = 0;
    for (int i = 0; i < N; i++) c += m_vld[i];
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_vld[i] = 1'b0;
    m_drain = 1'b0;
    m_ack   = 1'b0;
    m_perf  = 0;
  endtask

  task automatic drive_idle();
    vb_cawt_create_req  = 1'b0;
    cawt_entry_vld      = '0;
    ca_wr_addr_hit_cawt = '0;
    ca_rd_addr_hit_cawt = '0;
    ebiu_cawt_rd_req    = 1'b0;
    cawt_bresp_vld      = 1'b0;
    cawt_bresp_id       = '0;
    ciu_cawt_sync_req   = 1'b0;
  endtask

  // Registered outputs and the ack, all defined by the reference state.
  task automatic check_regs(input string pfx);
    int c;
    c = occupancy();
    chk({pfx, "cnt"},   32'(cawt_cnt),          32'(c));
    chk({pfx, "full"},  32'(cawt_full),         32'(c == N));
    chk({pfx, "empty"}, 32'(cawt_empty),        32'(c == 0));
    chk({pfx, "ack"},   32'(cawt_ciu_sync_ack), 32'(m_ack));
`ifdef CAWT_PERF_CNT_EN
    chk({pfx, "perf"},  32'(cawt_perf_full_stall), 32'(m_perf));
`endif
  endtask

  initial begin
    bit did_rst;
    int phase;
    did_rst = 1'b0;
    model_reset();
    for (int i = 0; i < N; i++) m_tag[i] = 8'(i);
    cpurst_b = 1'b0;
    drive_idle();
    repeat (3) @(negedge cawt_ctrl_clk);
    #1;
    check_regs("rst_");
    chk("rst_gnt",   32'(cawt_vb_create_gnt), 32'd0);
    chk("rst_cen",   32'(cawt_create_en),     32'd0);
    chk("rst_pop",   32'(cawt_pop_en),        32'd0);
    chk("rst_stall", 32'(cawt_ebiu_rd_stall), 32'd0);
    @(negedge cawt_ctrl_clk);
    cpurst_b = 1'b1;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit       e_gnt, e_pop, e_blk, e_stall, any_free;
      int       e_id, cur;
      @(negedge cawt_ctrl_clk);

      // Mid-operation reset, preferably while a drain is outstanding.
      if (!did_rst && ((m_drain && occupancy() >= 3 && cyc >= 500) || cyc == 2000)) begin
        did_rst  = 1'b1;
        cpurst_b = 1'b0;
        drive_idle();
        model_reset();
        #1;
        check_regs("midrst_");
        @(negedge cawt_ctrl_clk);
        cpurst_b = 1'b1;
        continue;
      end

      // Phases: fill-heavy with unique lines, mixed with line collisions, drain-heavy.
      phase = (cyc / 250) % 3;
      vb_cawt_create_req = (phase == 0) ? ($urandom_range(0, 9) != 0)
                         : (phase == 1) ? ($urandom_range(0, 1) == 0)
                                        : ($urandom_range(0, 4) == 0);
      wr_line = (phase == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
      rd_line = 8'($urandom_range(0, 7));
      ebiu_cawt_rd_req = $urandom_range(0, 1);
      cawt_bresp_vld = (phase == 0) ? ($urandom_range(0, 9) == 0)
                     : (phase == 1) ? ($urandom_range(0, 1) == 0)
                                    : ($urandom_range(0, 4) != 0);
      cawt_bresp_id = IDW'($urandom_range(0, N - 1));
      if ($urandom_range(0, 4) != 0)
        for (int k = 0; k < N; k++) begin
          int j;
          j = (int'(cawt_bresp_id) + k) % N;
          if (m_vld[j]) begin
            cawt_bresp_id = IDW'(j);
            break;
          end
        end
      if (m_ack)        ciu_cawt_sync_req = 1'b0;
      else if (m_drain) ciu_cawt_sync_req = 1'b1;
      else              ciu_cawt_sync_req = ($urandom_range(0, 39) == 0);

      // Present the array view; stale tags of idle entries must be masked by the DUT.
      for (int i = 0; i < N; i++) begin
        cawt_entry_vld[i]      = m_vld[i];
        ca_wr_addr_hit_cawt[i] = (m_tag[i] == wr_line);
        ca_rd_addr_hit_cawt[i] = (m_tag[i] == rd_line);
      end

      // Expected combinational behaviour.
      any_free = 1'b0;
      e_id     = 0;
      for (int i = N - 1; i >= 0; i--)
        if (!m_vld[i]) begin
          any_free = 1'b1;
          e_id     = i;
        end
      e_blk   = 1'b0;
      e_stall = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (m_vld[i] && m_tag[i] == wr_line) e_blk = 1'b1;
        if (m_vld[i] && m_tag[i] == rd_line) e_stall = 1'b1;
      end
      e_gnt   = vb_cawt_create_req && any_free && !e_blk && !m_drain && !m_ack;
      e_pop   = cawt_bresp_vld && m_vld[cawt_bresp_id];
      e_stall = e_stall && ebiu_cawt_rd_req;

      #1;
      check_regs("");
      chk("gnt",   32'(cawt_vb_create_gnt), 32'(e_gnt));
      if (e_gnt) chk("id", 32'(cawt_create_id), 32'(e_id));
      chk("cen",   32'(cawt_create_en),     e_gnt ? (32'd1 << e_id) : 32'd0);
      chk("dpen",  32'(cawt_create_dp_en),  e_gnt ? (32'd1 << e_id) : 32'd0);
      chk("pop",   32'(cawt_pop_en),        e_pop ? (32'd1 << cawt_bresp_id) : 32'd0);
      chk("stall", 32'(cawt_ebiu_rd_stall), 32'(e_stall));

      // Advance the reference to the state after this clock edge.
      cur = occupancy();
      if (e_gnt) begin
        m_vld[e_id] = 1'b1;
        m_tag[e_id] = wr_line;
      end
      if (e_pop) m_vld[cawt_bresp_id] = 1'b0;
      if (m_ack) m_ack = 1'b0;
      else if (m_drain) begin
        if (occupancy() == 0) begin
          m_drain = 1'b0;
          m_ack   = 1'b1;
        end
      end else if (ciu_cawt_sync_req) begin
        if (cur == 0 && !e_gnt) m_ack = 1'b1;
        else                    m_drain = 1'b1;
      end
      if (vb_cawt_create_req && !e_gnt && m_perf < 65535) m_perf++;
    end

    @(negedge cawt_ctrl_clk);
    drive_idle();
    #1;
    check_regs("end_");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
